// File: rtl/input_cmd_scheduler.sv
// Button front end for the tile game: synchronise and debounce the five buttons,
// turn presses and held-direction auto-repeat into commands, and release at most one per frame.
module input_cmd_scheduler #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_FRAMES   = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] btn_raw,
    input  logic       frame_start,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    input  logic       cmd_ready,
    output logic [4:0] btn_level,
    output logic [4:0] fifo_count,
    output logic       overflow,
    output logic [7:0] drop_count
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int REP_W = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_LAST = (REPEAT_FRAMES > 0) ? REP_W'(REPEAT_FRAMES - 1) : '0;
    localparam logic [4:0]       DEPTH    = 5'(FIFO_DEPTH);

    localparam logic [2:0] CMD_NONE   = 3'd0;
    localparam logic [2:0] CMD_UP     = 3'd1;
    localparam logic [2:0] CMD_DOWN   = 3'd2;
    localparam logic [2:0] CMD_LEFT   = 3'd3;
    localparam logic [2:0] CMD_RIGHT  = 3'd4;
    localparam logic [2:0] CMD_SELECT = 3'd5;

    typedef enum logic {S_WAIT, S_ISSUE} state_t;

    logic [4:0]       r_sync1, r_sync2, r_level, r_level_d;
    logic [CNT_W-1:0] r_deb_cnt [5];

    // NOTE: state updates use <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_level   <= '0;
            r_level_d <= '0;
            for (int i = 0; i < 5; i++) r_deb_cnt[i] <= '0;
        end else begin
            r_sync1   <= btn_raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            for (int i = 0; i < 5; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_level[i]   <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic [4:0] w_rise;
    logic       w_change;
    logic [2:0] w_press_code, w_held_code, w_push_code;
    logic       w_rep_fire;

    assign w_rise   = r_level & ~r_level_d;
    assign w_change = (r_level != r_level_d);

    // NOTE: defaulting first keeps this block purely combinational (no latch on the no-edge path).
    always_comb begin
        w_press_code = CMD_NONE;
        if      (w_rise[0]) w_press_code = CMD_UP;
        else if (w_rise[2]) w_press_code = CMD_DOWN;
        else if (w_rise[3]) w_press_code = CMD_LEFT;
        else if (w_rise[4]) w_press_code = CMD_RIGHT;
        else if (w_rise[1]) w_press_code = CMD_SELECT;
    end

    always_comb begin
        w_held_code = CMD_NONE;
        if      (r_level[0]) w_held_code = CMD_UP;
        else if (r_level[2]) w_held_code = CMD_DOWN;
        else if (r_level[3]) w_held_code = CMD_LEFT;
        else if (r_level[4]) w_held_code = CMD_RIGHT;
    end

    generate
        if (REPEAT_FRAMES > 0) begin : g_repeat
            logic [REP_W-1:0] r_rep_cnt;

            assign w_rep_fire = !w_change && (w_held_code != CMD_NONE) && frame_start
                                && (r_rep_cnt == REP_LAST);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rep_cnt <= '0;
                end else if (w_change || w_held_code == CMD_NONE) begin
                    r_rep_cnt <= '0;
                end else if (frame_start) begin
                    r_rep_cnt <= (r_rep_cnt == REP_LAST) ? '0 : r_rep_cnt + 1'b1;
                end
            end
        end else begin : g_no_repeat
            assign w_rep_fire = 1'b0;
        end
    endgenerate

    // A fresh press always wins over a repeat landing in the same cycle.
    assign w_push_code = (w_press_code != CMD_NONE) ? w_press_code
                       : (w_rep_fire ? w_held_code : CMD_NONE);

    logic [2:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr, r_rptr;
    logic [4:0]       r_count;
    logic             r_overflow, r_valid;
    logic [7:0]       r_drops;
    logic [2:0]       r_code;
    state_t           r_state;
    logic             w_pop, w_full, w_push, w_drop;

    assign w_pop  = r_valid & cmd_ready;
    assign w_full = (r_count == DEPTH);
    assign w_push = (w_push_code != CMD_NONE) & (!w_full | w_pop);
    assign w_drop = (w_push_code != CMD_NONE) & w_full & !w_pop;

    // NOTE: queue storage needs no reset; only the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_push_code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drops    <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            r_overflow <= w_drop;
            if (w_drop && r_drops != 8'hFF) r_drops <= r_drops + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_WAIT;
            r_valid <= 1'b0;
            r_code  <= CMD_NONE;
        end else begin
            case (r_state)
                S_WAIT: if (frame_start && r_count != 5'd0) begin
                    r_state <= S_ISSUE;
                    r_valid <= 1'b1;
                    r_code  <= r_mem[r_rptr];
                end
                S_ISSUE: if (cmd_ready) begin
                    r_state <= S_WAIT;
                    r_valid <= 1'b0;
                    r_code  <= CMD_NONE;
                end
                default: r_state <= S_WAIT;
            endcase
        end
    end

    assign cmd_valid  = r_valid;
    assign cmd_code   = r_code;
    assign btn_level  = r_level;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign drop_count = r_drops;

endmodule

// File: doc/input_cmd_scheduler.md
Name: input_cmd_scheduler

Overview:
- Converts the five raw board buttons into debounced, edge-detected game commands.
- Queues commands in a small FIFO and issues at most one per video frame to the tile-sort game logic, using a valid/ready handshake.
- Sits between the button pins and the tile game core, sequencing game-state updates so they land during vertical blank.
- Also provides debounced levels for LED mirroring.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles needed to accept a level change (1 ms at 50 MHz); minimum 1.
- CNT_W, 16: width of each debounce counter; must hold DEBOUNCE_CYCLES.
- FIFO_DEPTH, 4: command FIFO entries; power of two, 2..16.
- REPEAT_FRAMES, 15: frames a held direction button waits before auto-repeat; 0 disables auto-repeat.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- btn_raw  in  5  raw buttons, active high, asynchronous: [0]=up, [1]=center, [2]=down, [3]=left, [4]=right.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- cmd_valid  out  1  command offered to the game core.
- cmd_code  out  3  1=UP, 2=DOWN, 3=LEFT, 4=RIGHT, 5=SELECT; 0 when cmd_valid=0.
- cmd_ready  in  1  game core accepts the command when cmd_valid and cmd_ready are both high.
- btn_level  out  5  debounced button levels.
- fifo_count  out  5  entries currently queued (0..FIFO_DEPTH).
- overflow  out  1  one-cycle pulse when a command is dropped.
- drop_count  out  8  saturating count of dropped commands.

Behaviour:
- Reset (async assert, sync release): all of the following are 0 — cmd_valid, cmd_code, btn_level, fifo_count, overflow, drop_count; also the synchronizers, counters, FIFO pointers and repeat counter. FSM goes to S_WAIT.
- Reset mid-handshake discards the offered command and the whole queue.
- Sync: each btn_raw bit passes through a 2-flop synchronizer.
- Debounce (per bit):
  - The counter clears whenever the synced value equals btn_level.
  - Otherwise it increments; when it reaches DEBOUNCE_CYCLES-1, btn_level takes the synced value and the counter clears.
  - Any bounce back resets the count. Total raw-to-btn_level latency is DEBOUNCE_CYCLES+2 cycles.
- Press event:
  - Occurs on a btn_level rising edge (registered previous level); release produces nothing.
  - At most one push per cycle. If several edges occur in the same cycle, only the highest priority is pushed: UP > DOWN > LEFT > RIGHT > SELECT. The others are discarded silently (not counted as overflow).
- Auto-repeat (REPEAT_FRAMES>0):
  - Tracks the highest-priority held direction button; SELECT never repeats.
  - The counter increments on each frame_start while that button is held and clears on any btn_level change.
  - On reaching REPEAT_FRAMES it requests a push of that code and clears.
  - A press event in the same cycle takes precedence; the repeat request is discarded.
- FIFO:
  - Push when a command is generated and (count<FIFO_DEPTH or pop this cycle).
  - Simultaneous push and pop when full is allowed; count is unchanged.
  - Push while full with no pop drops the command: overflow=1 for that cycle, drop_count+1, saturating at 255.
  - Pop on cmd_valid & cmd_ready.
  - Pointers wrap modulo FIFO_DEPTH.
- Issue FSM:
  - S_WAIT: cmd_valid=0. On frame_start with fifo_count>0, go to S_ISSUE; cmd_valid=1 and cmd_code=head appear on the next cycle. A frame_start with an empty FIFO is ignored, so a command queued mid-frame waits for the next frame_start.
  - S_ISSUE: cmd_valid and cmd_code are held stable until accepted. On cmd_ready, pop and return to S_WAIT; cmd_valid falls the next cycle. frame_start in S_ISSUE is ignored; there is no timeout.
  - Result: at most one accepted command per frame.
- All outputs are registered.

Test Plan:
- DEBOUNCE_CYCLES=4, btn_raw[0] high, steady -> btn_level[0] rises 6 cycles later; fifo_count goes 0->1 the next cycle; after the next frame_start, cmd_valid=1 with cmd_code=1; with cmd_ready=1 the command is accepted in one cycle and fifo_count=0.
- btn_raw[3] toggles every 2 cycles for 40 cycles, then stays low -> btn_level[3] stays 0, no push, fifo_count=0.
- FIFO_DEPTH=4, cmd_ready=0, five distinct presses (down, left, right, center, down) -> fifo_count=4; overflow pulses once on the 5th; drop_count=1; after frame_start, cmd_code=2 is held until cmd_ready is asserted.
- up and right debounce in the same cycle -> exactly one push, UP (code 1); fifo_count=1; no overflow.
- REPEAT_FRAMES=3, left held across 10 frame_starts with cmd_ready=1 -> 1 press plus 3 repeats queued (codes all 3); one command issued per frame; releasing center-held SELECT produces no repeat.
- rst_n low while cmd_valid=1 and fifo_count=3 -> cmd_valid, cmd_code, fifo_count and drop_count go to 0 immediately; after release, the first frame_start produces no command.
